ethernet_tx_framer: RTL and testbench
=====================================

# ethernet_tx_framer

Byte-wide Ethernet MAC transmit framer sitting between the TX payload FIFO and the MII/RMII byte serializer. It wraps each frame in the 7-byte preamble and the SFD, and pads short frames with zeros. It appends the 4-byte FCS, computed by an `ethernet_crc32` instance, then enforces the inter-frame gap. Each input frame is an already-built destination/source/type/payload byte stream delimited by `last_i`.

## Interface
- `MIN_FRAME`, 60, minimum bytes (data + pad) before the FCS; 0 disables padding.
- `IFG_BYTES`, 12, idle byte-times after the FCS before the next preamble.
- `clk_i  in  1  clock`
- `rst_n_i  in  1  reset, asynchronous, active-low`
- `data_i  in  8  payload byte`
- `valid_i  in  1  data_i valid`
- `last_i  in  1  data_i is the final byte of the frame`
- `ready_o  out  1  payload byte accepted when valid_i && ready_o`
- `tx_data_o  out  8  byte to serializer`
- `tx_valid_o  out  1  transmit enable; high for the whole frame`
- `tx_ready_i  in  1  serializer consumed tx_data_o this cycle`
- `underrun_o  out  1  one-cycle pulse: payload starved mid-frame, frame aborted`
- `busy_o  out  1  state != IDLE`

## Operation
- FSM states: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, DISCARD.
- IDLE:
  - The FSM leaves IDLE for PREAMBLE when `valid_i` is high.
  - No byte is consumed at this transition.
- PREAMBLE: emits 0x55 seven times, then moves to SFD.
- SFD:
  - Emits 0xD5.
  - Pulses `initialize_i` of the CRC so the register becomes 0xFFFFFFFF.
- DATA:
  - `ready_o` = output slot free.
  - On each accept, the byte goes to `tx_data_o`, `compute_i` is pulsed, and the CRC is fed `data_i` bit-reversed (bit 0 ↔ bit 7).
  - The length counter increments on each accept.
  - On an accept with `last_i`: the FSM goes to PAD if count < `MIN_FRAME`, otherwise to FCS.
- PAD:
  - Emits 0x00 and feeds it to the CRC like DATA bytes.
  - Continues until count == `MIN_FRAME`, then moves to FCS.
- FCS:
  - The CRC is frozen.
  - FCS = ~bitreverse32(crc32_o), sent least-significant byte first over 4 bytes.
- IFG:
  - `tx_valid_o` stays low for `IFG_BYTES` × `tx_ready_i` strobes.
  - The serializer keeps strobing during idle.
  - Then the FSM returns to IDLE.
- Underrun (DATA, output slot free, `valid_i` low):
  - Pulse `underrun_o` and drop `tx_valid_o`.
  - Enter DISCARD: `ready_o` = 1, consume input until an accepted `last_i`, then go to IFG.
- Length counter:
  - 16-bit, saturating at 0xFFFF.
  - Cleared on entry to PREAMBLE.
  - No maximum-length check.
- Byte-time counter (preamble/IFG/FCS index) is shared and cleared on every state change.

## Timing
- Reset values:
  - `tx_data_o` = 0x00; `tx_valid_o`, `ready_o`, `underrun_o`, `busy_o` = 0.
  - FSM = IDLE; CRC register = 0xFFFFFFFF.
- `tx_data_o`/`tx_valid_o` are registered (one-byte output slot).
  - Slot free = `!tx_valid_o || tx_ready_i`.
  - The FSM advances only when the slot is free.
- `ready_o` is combinational from state and slot-free. Payload-to-`tx_data_o` latency is 1 cycle.
- CRC update occurs in the same cycle the byte loads into the slot. `crc32_o` is valid for FCS the cycle after the last DATA/PAD load.
- `tx_valid_o` is continuous from the first preamble byte to the last FCS byte; the only drop mid-frame is underrun.
- Latency from `valid_i` rise in IDLE to the first 0x55 on `tx_data_o`: 1 cycle. The first payload byte follows 8 slot loads later.
- A `last_i` on the first payload byte is legal: a 1-byte frame is padded to `MIN_FRAME`.
- `valid_i` during PREAMBLE/SFD/FCS/IFG is held off with `ready_o` = 0.
- Asynchronous reset mid-frame:
  - Immediate IDLE, `tx_valid_o` = 0; no FCS is emitted.
  - Upstream must flush its partial frame.

## Structure
- `ethernet_pkg`:
  - typedef `tx_framer_state_t`.
  - Constants `ETH_PREAMBLE` = 8'h55, `ETH_SFD` = 8'hD5, `ETH_PREAMBLE_LEN` = 7.
  - Function `bit_reverse8`.
- One sub-module: `ethernet_crc32` (`initialize_i`, `compute_i`, `data_i`, `crc32_o`), driven only by the FSM.

## Test plan
- `MIN_FRAME`=0, payload ASCII "123456789" (0x31..0x39), `tx_ready_i` = 1:
  - `tx_data_o` = 7×0x55, 0xD5, 0x31..0x39, then 0x26, 0x39, 0xF4, 0xCB.
  - `tx_valid_o` low for exactly 12 cycles after that.
- `MIN_FRAME`=60, 14-byte header only:
  - 46 bytes of 0x00 are padded.
  - 60 data + 4 FCS bytes; the receive-side CRC over data+FCS yields residue 0xC704DD7B.
- `tx_ready_i` asserted every 4th cycle (RMII 100M):
  - `tx_data_o` holds each byte until its strobe.
  - The byte stream is identical to the first scenario.
- `valid_i` dropped after 5 payload bytes, 20 bytes remaining:
  - `underrun_o` pulses once and `tx_valid_o` falls.
  - All 20 remaining bytes are accepted and discarded.
  - IFG is observed, then a new frame transmits correctly.
- Back-to-back frames with `valid_i` held high:
  - Exactly 12 idle byte-times between FCS byte 4 and the next 0x55.
- `rst_n_i` asserted during PAD:
  - Outputs go to reset values immediately.
  - After release, a clean frame transmits with correct FCS.

Source files
------------

// File: rtl/ethernet_tx_framer_pkg.sv
// Shared types, constants and bit-order helpers for the Ethernet TX framer.
package ethernet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG,
    DISCARD
  } tx_framer_state_t;

  localparam logic [7:0]  ETH_PREAMBLE     = 8'h55;
  localparam logic [7:0]  ETH_SFD          = 8'hD5;
  localparam int          ETH_PREAMBLE_LEN = 7;
  localparam int          ETH_FCS_LEN      = 4;
  localparam logic [31:0] ETH_CRC_POLY     = 32'h04C1_1DB7;
  // Byte-time counter width; IFG_BYTES must fit in it.
  localparam int          CNT_W            = 8;

  function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bit_reverse32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

endpackage

// File: rtl/ethernet_tx_framer_crc32.sv
// MSB-first CRC-32 (poly 0x04C11DB7) register, one byte per compute strobe.
module ethernet_crc32
  import ethernet_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        initialize_i,
  input  logic        compute_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc32_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc_q;
    for (int i = 7; i >= 0; i--) begin
      if (crc_next[31] ^ data_i[i]) crc_next = {crc_next[30:0], 1'b0} ^ ETH_CRC_POLY;
      else                          crc_next = {crc_next[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)          crc_q <= '1;
    else if (initialize_i) crc_q <= '1;
    else if (compute_i)    crc_q <= crc_next;
  end

  assign crc32_o = crc_q;

endmodule

// File: rtl/ethernet_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble/SFD, payload, zero pad, FCS and
// inter-frame gap, feeding a one-byte registered output slot.
module ethernet_tx_framer
  import ethernet_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       underrun_o,
  output logic       busy_o
);

  localparam logic [15:0]      MIN_LEN  = 16'(MIN_FRAME);
  // The IDLE exit loads the first 0x55, so PREAMBLE loads the remaining six.
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(ETH_PREAMBLE_LEN - 2);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(ETH_FCS_LEN - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);

  tx_framer_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      len_q, len_d, len_inc;
  logic [16:0]      pad_gap;
  logic             short_frame;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             underrun_q, underrun_d;
  logic             slot_free;
  logic             load;
  logic [7:0]       load_data;
  logic             crc_init, crc_compute;
  logic [7:0]       crc_data;
  logic [31:0]      crc32;
  logic [31:0]      fcs;

  ethernet_crc32 u_crc (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .initialize_i (crc_init),
    .compute_i    (crc_compute),
    .data_i       (crc_data),
    .crc32_o      (crc32)
  );

  assign slot_free = !tx_valid_q || tx_ready_i;
  assign len_inc   = (&len_q) ? len_q : len_q + 16'd1;
  // Sign of (MIN - len) decides padding without a constant-zero compare.
  assign pad_gap     = {1'b0, MIN_LEN} - {1'b0, len_inc};
  assign short_frame = !pad_gap[16] && (pad_gap != 17'd0);
  assign fcs         = ~bit_reverse32(crc32);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    load        = 1'b0;
    load_data   = 8'h00;
    crc_init    = 1'b0;
    crc_compute = 1'b0;
    crc_data    = 8'h00;
    underrun_d  = 1'b0;
    ready_o     = 1'b0;
    case (state_q)
      IDLE: if (valid_i && slot_free) begin
        load      = 1'b1;
        load_data = ETH_PREAMBLE;
        len_d     = '0;
        state_d   = PREAMBLE;
      end
      PREAMBLE: if (slot_free) begin
        load      = 1'b1;
        load_data = ETH_PREAMBLE;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == PRE_LAST) state_d = SFD;
      end
      SFD: if (slot_free) begin
        load      = 1'b1;
        load_data = ETH_SFD;
        crc_init  = 1'b1;
        state_d   = DATA;
      end
      DATA: begin
        ready_o = slot_free;
        if (slot_free) begin
          if (valid_i) begin
            load        = 1'b1;
            load_data   = data_i;
            crc_compute = 1'b1;
            crc_data    = bit_reverse8(data_i);
            len_d       = len_inc;
            if (last_i) state_d = short_frame ? PAD : FCS;
          end else begin
            underrun_d = 1'b1;
            state_d    = DISCARD;
          end
        end
      end
      PAD: if (slot_free) begin
        load        = 1'b1;
        crc_compute = 1'b1;
        len_d       = len_inc;
        if (len_inc == MIN_LEN) state_d = FCS;
      end
      FCS: if (slot_free) begin
        load      = 1'b1;
        load_data = fcs[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == FCS_LAST) state_d = IFG;
      end
      // Every serializer strobe counts, including the one that drains FCS byte 4.
      IFG: if (tx_ready_i) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == IFG_LAST) state_d = IDLE;
      end
      DISCARD: begin
        ready_o = 1'b1;
        if (valid_i && last_i) state_d = IFG;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      underrun_q <= underrun_d;
      if (slot_free) begin
        tx_valid_q <= load;
        if (load) tx_data_q <= load_data;
      end
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign underrun_o = underrun_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_ethernet_tx_framer.sv
// Directed bench: two framer instances (MIN_FRAME 0 and 60) behind a selector.
module tb_ethernet_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0, last = 1'b0, txr = 1'b1;

  logic [7:0] tx_data_a, tx_data_b;
  logic       ready_a, ready_b, tx_valid_a, tx_valid_b;
  logic       underrun_a, underrun_b, busy_a, busy_b;

  logic [7:0] tx_data;
  logic       ready, tx_valid, underrun, busy;

  always #5 clk = ~clk;

  ethernet_tx_framer #(.MIN_FRAME(0), .IFG_BYTES(12)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .data_i(sel ? 8'h00 : data), .valid_i(valid && !sel), .last_i(last && !sel),
    .ready_o(ready_a), .tx_data_o(tx_data_a), .tx_valid_o(tx_valid_a),
    .tx_ready_i(sel ? 1'b1 : txr), .underrun_o(underrun_a), .busy_o(busy_a)
  );

  ethernet_tx_framer #(.MIN_FRAME(60), .IFG_BYTES(12)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .data_i(sel ? data : 8'h00), .valid_i(valid && sel), .last_i(last && sel),
    .ready_o(ready_b), .tx_data_o(tx_data_b), .tx_valid_o(tx_valid_b),
    .tx_ready_i(sel ? txr : 1'b1), .underrun_o(underrun_b), .busy_o(busy_b)
  );

  assign tx_data  = sel ? tx_data_b  : tx_data_a;
  assign ready    = sel ? ready_b    : ready_a;
  assign tx_valid = sel ? tx_valid_b : tx_valid_a;
  assign underrun = sel ? underrun_b : underrun_a;
  assign busy     = sel ? busy_b     : busy_a;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  bit slow = 1'b0;

  logic [7:0] src_d[$];
  bit         src_l[$];
  int         src_idx = 0;
  int         gap_at = -1;
  int         gap_left = 0;

  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  int         gaps[$];
  int         low_run = 0;
  bit         seen_high = 1'b0;
  bit         pend = 1'b0;
  logic [7:0] pend_data = 8'h00;
  int         hold_bad = 0;
  int         un_cnt = 0;
  int         first_valid_cyc = -1;
  int         first_tx_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic add_src(input logic [7:0] p[$]);
    foreach (p[i]) begin
      src_d.push_back(p[i]);
      src_l.push_back(i == p.size() - 1);
    end
  endtask

  task automatic add_frame(input logic [7:0] p[$], input int min_len);
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    n = (p.size() > min_len) ? p.size() : min_len;
    for (int i = 0; i < n; i++) begin
      b = (i < p.size()) ? p[i] : 8'h00;
      exp_q.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic clear_all();
    src_d.delete(); src_l.delete(); src_idx = 0; gap_at = -1; gap_left = 0;
    out_q.delete(); exp_q.delete(); gaps.delete();
    low_run = 0; seen_high = 1'b0; pend = 1'b0; hold_bad = 0; un_cnt = 0;
    first_valid_cyc = -1; first_tx_cyc = -1;
  endtask

  // Drive inputs after the falling edge, then sample what the next rising edge will see.
  task automatic tick();
    bit in_gap;
    @(negedge clk);
    cyc++;
    txr = slow ? (cyc % 4 == 0) : 1'b1;
    in_gap = (src_idx == gap_at) && (gap_left > 0);
    if (src_idx < src_d.size() && !in_gap) begin
      valid = 1'b1; data = src_d[src_idx]; last = src_l[src_idx];
    end else begin
      if (in_gap) gap_left--;
      valid = 1'b0; data = 8'h00; last = 1'b0;
    end
    #1;
    if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (tx_valid && first_tx_cyc < 0) first_tx_cyc = cyc;
    if (tx_valid && txr) out_q.push_back(tx_data);
    if (pend && tx_valid && tx_data !== pend_data) hold_bad++;
    pend = tx_valid && !txr;
    pend_data = tx_data;
    if (underrun) un_cnt++;
    if (tx_valid) begin
      if (seen_high && low_run > 0) gaps.push_back(low_run);
      low_run = 0;
      seen_high = 1'b1;
    end else if (seen_high) begin
      low_run++;
    end
    if (valid && ready) src_idx++;
  endtask

  task automatic run_frames(input string tag, input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (src_idx >= src_d.size()) && !busy && !tx_valid;
    end
    chk({tag, "_timeout"}, 32'(!done), 32'd0);
  endtask

  task automatic chk_stream(input string tag);
    int n;
    chk({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [7:0]  p9[$];
    logic [7:0]  hdr[$];
    logic [7:0]  p25[$];
    logic [31:0] c;
    logic [31:0] rev;

    for (int i = 0; i < 9; i++) p9.push_back(8'(8'h31 + i));
    for (int i = 0; i < 14; i++) hdr.push_back(8'(i * 17 + 3));
    for (int i = 0; i < 25; i++) p25.push_back(8'(8'hA0 + i));

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // MIN_FRAME=0, "123456789" twice back-to-back with valid held high
    clear_all();
    sel = 1'b0; slow = 1'b0;
    add_src(p9); add_src(p9);
    add_frame(p9, 0); add_frame(p9, 0);
    run_frames("b2b", 2000);
    chk_stream("b2b");
    chk("b2b_latency", 32'(first_tx_cyc - first_valid_cyc), 32'd1);
    if (out_q.size() >= 21) begin
      chk("fcs0", 32'(out_q[17]), 32'h26);
      chk("fcs1", 32'(out_q[18]), 32'h39);
      chk("fcs2", 32'(out_q[19]), 32'hF4);
      chk("fcs3", 32'(out_q[20]), 32'hCB);
    end else begin
      chk("fcs_present", 32'(out_q.size()), 32'd21);
    end
    chk("b2b_gap_count", 32'(gaps.size()), 32'd1);
    if (gaps.size() > 0) chk("b2b_ifg", 32'(gaps[0]), 32'd12);

    // MIN_FRAME=60, 14-byte header padded to 60
    clear_all();
    sel = 1'b1; slow = 1'b0;
    add_src(hdr);
    add_frame(hdr, 60);
    run_frames("pad", 2000);
    chk_stream("pad");
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < out_q.size(); i++) c = crc_step(c, out_q[i]);
    for (int i = 0; i < 32; i++) rev[i] = c[31-i];
    chk("pad_residue", rev, 32'hC704_DD7B);

    // Serializer strobing every 4th cycle
    clear_all();
    sel = 1'b0; slow = 1'b1;
    add_src(p9);
    add_frame(p9, 0);
    run_frames("slow", 4000);
    chk_stream("slow");
    chk("slow_hold", 32'(hold_bad), 32'd0);
    slow = 1'b0;

    // Underrun after 5 payload bytes, then a fresh frame
    clear_all();
    sel = 1'b1;
    add_src(p25); add_src(hdr);
    gap_at = 5; gap_left = 3;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 5; i++) exp_q.push_back(p25[i]);
    add_frame(hdr, 60);
    run_frames("underrun", 3000);
    chk_stream("underrun");
    chk("underrun_pulses", 32'(un_cnt), 32'd1);
    chk("underrun_consumed", 32'(src_idx), 32'd39);
    chk("underrun_gap_count", 32'(gaps.size()), 32'd1);
    if (gaps.size() > 0) chk("underrun_gap_ge32", 32'(gaps[0] >= 32), 32'd1);

    // Asynchronous reset while padding, then a clean frame
    clear_all();
    sel = 1'b1;
    add_src(hdr);
    repeat (32) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    src_idx = src_d.size();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    clear_all();
    add_src(hdr);
    add_frame(hdr, 60);
    run_frames("post_rst", 2000);
    chk_stream("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
